// File: rtl/rapcla_seq_adder_ctrl.sv
// Sequential approximate-CLA controller: one VALENCY-bit chunk per cycle, LSB first.
// Latency: N+1 cycles from accepted start to the done cycle (N = WIDTH/VALENCY).
// Backpressure: none; start is only sampled in IDLE/DONE and ignored while busy.
module rapcla_seq_adder_ctrl #(
  parameter int WIDTH   = 32,
  parameter int VALENCY = 4,
  parameter int KW      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [KW-1:0]    approx_k,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int N = WIDTH / VALENCY;
  // Chunk count and last index expressed at the width of the index/k registers.
  localparam logic [KW-1:0] N_K  = KW'(N);
  localparam logic [KW-1:0] LAST = KW'(N - 1);
  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({VALENCY{1'b1}});

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [KW-1:0]      k_q;
  logic [KW-1:0]      idx;
  logic               carry;
  logic [WIDTH-1:0]   res;

  int                 sh;
  logic [VALENCY-1:0] ca;
  logic [VALENCY-1:0] cb;
  logic [VALENCY-1:0] g;
  logic [VALENCY-1:0] p;
  logic [VALENCY-1:0] s;
  logic               gg;
  logic               gp;
  logic               c_rip;
  logic               carry_next;
  logic [WIDTH-1:0]   res_next;
  logic [KW-1:0]      k_clamped;

  // approx_k values above N simply mean "every chunk speculative".
  assign k_clamped = (approx_k > N_K) ? N_K : approx_k;

  // Shared group cell plus in-chunk ripple for the chunk selected by idx.
  always_comb begin
    sh    = int'(idx) * VALENCY;
    ca    = VALENCY'(a_q >> sh);
    cb    = VALENCY'(b_q >> sh);
    g     = ca & cb;
    p     = ca ^ cb;
    gg    = 1'b0;
    gp    = 1'b1;
    c_rip = carry;
    s     = '0;
    for (int j = 0; j < VALENCY; j++) begin
      gg    = g[j] | (p[j] & gg);
      gp    = gp & p[j];
      s[j]  = p[j] ^ c_rip;
      c_rip = g[j] | (p[j] & c_rip);
    end
    // Low chunks forward only their own generate; the incoming carry is dropped.
    carry_next = (idx < k_q) ? gg : (gg | (gp & carry));
    res_next   = (res & ~(CHUNK_MASK << sh)) | (WIDTH'(s) << sh);
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      carry <= 1'b0;
      idx   <= '0;
      k_q   <= '0;
      res   <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            k_q   <= k_clamped;
            carry <= cin;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          res   <= res_next;
          carry <= carry_next;
          if (idx == LAST) begin
            sum   <= res_next;
            cout  <= carry_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + KW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
